// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART widths, receiver state codes and FIFO operation codes
package uart_rx_fifo_pkg;

  localparam int UART_B           = 8;
  localparam int UART_FIFO_ADDR_W = 4;

  // Receiver FSM encodings, kept here so benches can decode the receiver state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DESFASO = 3'd1,
    ESPERO  = 3'd2,
    RECIBO  = 3'd3,
    FIN     = 3'd4
  } uart_rx_state_e;

  // {w_edge, rd} request pair seen by the FIFO each cycle.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage array: synchronous write, asynchronous read, no reset
module fifo_ram #(
  parameter int B      = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [B-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [B-1:0]      rdata_o
);

  logic [B-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with edge-detected writes and sticky overrun
// Optional almost_full output and AF_LEVEL parameter under UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int B        = UART_B,
  parameter int ADDR_W   = UART_FIFO_ADDR_W
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = 12
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [B-1:0]    w_data,
  input  logic            rd,
  output logic [B-1:0]    r_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overrun,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  output logic            almost_full,
`endif
  input  logic            clr_ovr
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              wr_q, armed_q, armed_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              w_edge, do_push, do_pop, ovr_set;
  logic              empty_c, full_c;
  fifo_op_e          op;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == DEPTH);

  // armed_q stops a wr held high across reset from looking like a fresh edge.
  assign w_edge  = wr & ~wr_q & armed_q;
  assign armed_d = armed_q | ~wr;
  assign op      = fifo_op_e'({w_edge, rd});

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovr_set = 1'b0;
    unique case (op)
      OP_WR: begin
        if (full_c) ovr_set = 1'b1;
        else        do_push = 1'b1;
      end
      OP_RD: begin
        do_pop = ~empty_c;
      end
      OP_WR_RD: begin
        // An empty FIFO has no head to pop yet; full plus pop frees the slot being written.
        do_push = 1'b1;
        do_pop  = ~empty_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= 1'b0;
      armed_q   <= ~wr;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr;
      armed_q   <= armed_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= (count_q >= AF_CNT);
  end

  assign almost_full = almost_full_q;
`endif

  fifo_ram #(
    .B      (B),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (r_data)
  );

  assign empty   = empty_c;
  assign full    = full_c;
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] r_data;
  logic       empty, full, overrun;
  logic [4:0] count;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .clr_ovr     (clr_ovr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_prev_wr = 1'b0;
  logic       m_low_seen = 1'b0;
  logic       m_af = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance model and clock.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rst);
    bit rise, pop, push;
    wr = w; w_data = d; rd = r; clr_ovr = c; reset = rst;
    if (!rst) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 16));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (mq.size() != 0) chk("r_data", 32'(r_data), 32'(mq[0]));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("almost_full", 32'(almost_full), 32'(m_af));
`endif
    end
    if (rst) begin
      mq.delete();
      m_ovr = 1'b0;
      m_prev_wr = 1'b0;
      m_low_seen = !w;
      m_af = 1'b0;
    end else begin
      rise = w && !m_prev_wr && m_low_seen;
      pop  = r && mq.size() > 0;
      push = rise && (mq.size() < 16 || pop);
      m_af = (mq.size() >= 12);
      if (rise && mq.size() == 16 && !r) m_ovr = 1'b1;
      else if (c) m_ovr = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
      m_prev_wr = w;
      if (!w) m_low_seen = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wpulse(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic       wr_r;
    int         rd_pct;

    @(posedge clk); #1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_rdata", 32'(r_data), 32'hA5);
    chk("t1_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t1_empty", 32'(empty), 32'd1);

    repeat (20) cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd1);
    rd1();

    for (int i = 0; i < 16; i++) wpulse(8'(i));
    chk("t3_full", 32'(full), 32'd1);
    wpulse(8'hFF);
    chk("t3_ovr", 32'(overrun), 32'd1);
    chk("t3_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", 32'(r_data), 32'(i));
      rd1();
    end
    chk("t3_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_clr", 32'(overrun), 32'd0);

    for (int i = 0; i < 16; i++) wpulse(8'(8'h20 + i));
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_ovr", 32'(overrun), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) rd1();
    chk("t4_last", 32'(r_data), 32'h77);
    rd1();

    repeat (5) rd1();
    chk("t5_count", 32'(count), 32'd0);
    cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    chk("t5_rdata", 32'(r_data), 32'h11);
    chk("t5_count1", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) wpulse(8'(8'h40 + i));
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    repeat (3) cyc(1'b1, 8'h98, 1'b0, 1'b0, 1'b0);
    chk("t6_nowr", 32'(count), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t6_rearm", 32'(count), 32'd1);

    wr_r = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      rd_pct = (ph == 0) ? 10 : (ph == 1) ? 45 : (ph == 2) ? 85 : 30;
      for (int n = 0; n < 700; n++) begin
        if ($urandom_range(0, 2) == 0) wr_r = ~wr_r;
        cyc(wr_r, 8'($urandom), ($urandom_range(0, 99) < rd_pct),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
